vm_seg_display: RTL and testbench



---
 rtl/vm_seg_display.sv | 159 +++++++++++++++
 tb/tb_vm_seg_display.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vm_seg_display.sv
// rtl/vm_seg_display.sv - double-dabble BCD converter driving an 8-digit seven-segment bus
module vm_seg_display #(
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd,
    input  logic [7:0]  paid,
    input  logic [7:0]  consume,
    input  logic [7:0]  change,
    output logic        busy,
    output logic        done,
    output logic [55:0] LED
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    localparam logic [55:0] LED_OFF = (SEG_ACTIVE_LOW != 0) ? {56{1'b1}} : 56'd0;
    localparam logic [6:0]  SEG_DASH = 7'h40;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0][7:0] bin_q, bin_d;
    logic [2:0][9:0] bcd_q, bcd_d;
    logic            pending_q, pending_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [55:0]     led_q, led_d;
    logic [8:0]      step_bcd;
    logic [55:0]     seg_raw;
    logic [55:0]     seg_out;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'h3F;
            4'd1: s = 7'h06;
            4'd2: s = 7'h5B;
            4'd3: s = 7'h4F;
            4'd4: s = 7'h66;
            4'd5: s = 7'h6D;
            4'd6: s = 7'h7D;
            4'd7: s = 7'h07;
            4'd8: s = 7'h7F;
            4'd9: s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Hundreds never reaches 5 for an 8-bit input, so only tens and units are corrected.
    function automatic logic [8:0] dd_adjust(input logic [8:0] b);
        logic [8:0] r;
        r = b;
        if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
        if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
        return r;
    endfunction

    function automatic logic [13:0] field_seg(input logic [9:0] b);
        logic [6:0] tens;
        logic [13:0] r;
        if (b[9:8] != 2'd0) begin
            r = {SEG_DASH, SEG_DASH};
        end else begin
            tens = ((BLANK_LZ != 0) && (b[7:4] == 4'd0)) ? 7'h00 : seg7(b[7:4]);
            r = {tens, seg7(b[3:0])};
        end
        return r;
    endfunction

    always_comb begin
        seg_raw = {field_seg(bcd_q[0]), field_seg(bcd_q[1]), 14'd0, field_seg(bcd_q[2])};
        seg_out = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        led_d     = led_q;
        step_bcd  = 9'd0;
        case (state_q)
            S_IDLE: begin
                if (upd) begin
                    bin_d   = {change, consume, paid};
                    bcd_d   = '0;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (upd) pending_d = 1'b1;
                // cnt[4:3] selects the field: 0 = paid, 1 = consume, 2 = change
                for (int i = 0; i < 3; i++) begin
                    if (cnt_q[4:3] == 2'(i)) begin
                        step_bcd = dd_adjust(bcd_q[i][8:0]);
                        bcd_d[i] = {step_bcd, bin_q[i][7]};
                        bin_d[i] = {bin_q[i][6:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd23) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                led_d  = seg_out;
                done_d = 1'b1;
                if (pending_q || upd) begin
                    bin_d     = {change, consume, paid};
                    bcd_d     = '0;
                    cnt_d     = 5'd0;
                    pending_d = 1'b0;
                    state_d   = S_CONV;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            bin_q     <= '0;
            bcd_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            led_q     <= LED_OFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            led_q     <= led_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign LED  = led_q;

endmodule

// File: tb/tb_vm_seg_display.sv
// tb/tb_vm_seg_display.sv - randomized self-checking bench for vm_seg_display
module tb_vm_seg_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        upd = 1'b0;
    logic [7:0]  paid = 8'd0, consume = 8'd0, change = 8'd0;
    logic        busy, done, busy_l, done_l, busy_a, done_a;
    logic [55:0] led_d, led_l, led_a;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [55:0] OFF_AL = 56'hFF_FFFF_FFFF_FFFF;
    localparam logic [55:0] OFF_AH = 56'h0;

    logic [6:0]  segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [55:0] exp_d, exp_l, exp_a;

    always #5 clk = ~clk;

    vm_seg_display dut (
        .clk(clk), .rst(rst), .upd(upd), .paid(paid), .consume(consume),
        .change(change), .busy(busy), .done(done), .LED(led_d)
    );
    vm_seg_display #(.SEG_ACTIVE_LOW(1), .BLANK_LZ(1)) dut_lz (
        .clk(clk), .rst(rst), .upd(upd), .paid(paid), .consume(consume),
        .change(change), .busy(busy_l), .done(done_l), .LED(led_l)
    );
    vm_seg_display #(.SEG_ACTIVE_LOW(0), .BLANK_LZ(0)) dut_ah (
        .clk(clk), .rst(rst), .upd(upd), .paid(paid), .consume(consume),
        .change(change), .busy(busy_a), .done(done_a), .LED(led_a)
    );

    // Decimal digits by division; values of 100 and up show two dashes.
    function automatic logic [13:0] fld(input int v, input bit lz);
        logic [6:0] t;
        if (v >= 100) return {7'h40, 7'h40};
        t = (lz && (v / 10 == 0)) ? 7'h00 : segtab[v / 10];
        return {t, segtab[v % 10]};
    endfunction

    function automatic logic [55:0] exp_led(input int p, input int c, input int ch,
                                            input bit al, input bit lz);
        logic [55:0] r;
        r = {fld(p, lz), fld(c, lz), 14'd0, fld(ch, lz)};
        return al ? ~r : r;
    endfunction

    task automatic test_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        n_tests++;
        if (led_d !== OFF_AL || led_l !== OFF_AL || led_a !== OFF_AH) begin
            n_fail++;
            $display("FAIL reset_led: got %h/%h/%h want %h/%h/%h", led_d, led_l, led_a, OFF_AL, OFF_AL, OFF_AH);
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        exp_d = OFF_AL; exp_l = OFF_AL; exp_a = OFF_AH;
    endtask

    task automatic run_conv(input int p, input int c, input int ch, input string name);
        logic [55:0] nd, nl, na;
        int busy_cyc, done_edge, ndone;
        nd = exp_led(p, c, ch, 1'b1, 1'b0);
        nl = exp_led(p, c, ch, 1'b1, 1'b1);
        na = exp_led(p, c, ch, 1'b0, 1'b0);
        busy_cyc = 0; done_edge = -1; ndone = 0;
        @(negedge clk);
        paid = p[7:0]; consume = c[7:0]; change = ch[7:0]; upd = 1'b1;
        @(negedge clk); upd = 1'b0;
        for (int e = 0; e < 40; e++) begin
            if (busy) busy_cyc++;
            if (done) begin ndone++; done_edge = e; end
            if (e == 24) begin
                n_tests++;
                if (led_d !== exp_d || led_l !== exp_l || led_a !== exp_a) begin
                    n_fail++;
                    $display("FAIL %s led_hold: got %h want %h", name, led_d, exp_d);
                end
            end
            if (e == 25) begin
                n_tests++;
                if (led_d !== nd || led_l !== nl || led_a !== na || done_l !== 1'b1 || done_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s led: got %h/%h/%h want %h/%h/%h", name, led_d, led_l, led_a, nd, nl, na);
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (done_edge != 25 || ndone != 1) begin
            n_fail++;
            $display("FAIL %s done: got edge %0d count %0d want edge 25 count 1", name, done_edge, ndone);
        end
        n_tests++;
        if (busy_cyc != 25) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d want 25", name, busy_cyc);
        end
        exp_d = nd; exp_l = nl; exp_a = na;
    endtask

    task automatic test_basic();
        run_conv(25, 7, 18, "basic");
    endtask

    task automatic test_edges();
        run_conv(150, 7, 0, "edge150_lz");
        run_conv(99, 0, 0, "edge99_zero");
        run_conv(100, 255, 9, "edge100");
        run_conv(0, 10, 100, "edge0");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_conv(int'($urandom_range(0, 255)), int'($urandom_range(0, 120)),
                     int'($urandom_range(0, 105)), "random");
    endtask

    task automatic test_pending();
        int c, ch, busy_cyc, ndone;
        logic [55:0] first_d, second_d, second_a;
        c = int'($urandom_range(0, 99)); ch = int'($urandom_range(0, 99));
        first_d  = exp_led(25, c, ch, 1'b1, 1'b0);
        second_d = exp_led(42, c, ch, 1'b1, 1'b0);
        second_a = exp_led(42, c, ch, 1'b0, 1'b0);
        busy_cyc = 0; ndone = 0;
        @(negedge clk);
        paid = 8'd25; consume = c[7:0]; change = ch[7:0]; upd = 1'b1;
        @(negedge clk); upd = 1'b0;
        for (int e = 0; e < 70; e++) begin
            if (busy) busy_cyc++;
            if (done) ndone++;
            if (e == 25) begin
                n_tests++;
                if (led_d !== first_d || done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pending_first: got %h done=%b want %h done=1", led_d, done, first_d);
                end
            end
            if (e == 50) begin
                n_tests++;
                if (led_d !== second_d || led_a !== second_a || done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pending_second: got %h/%h done=%b want %h/%h done=1", led_d, led_a, done, second_d, second_a);
                end
            end
            if (e == 9)  begin paid = 8'd30; upd = 1'b1; end
            if (e == 10) upd = 1'b0;
            if (e == 20) paid = 8'd42;
            @(negedge clk);
        end
        n_tests++;
        if (busy_cyc != 50 || ndone != 2) begin
            n_fail++;
            $display("FAIL pending_flags: got busy %0d done %0d want 50 2", busy_cyc, ndone);
        end
        exp_d = second_d; exp_l = exp_led(42, c, ch, 1'b1, 1'b1); exp_a = second_a;
    endtask

    task automatic test_abort();
        int ndone;
        ndone = 0;
        @(negedge clk);
        paid = 8'd64; consume = 8'd33; change = 8'd5; upd = 1'b1;
        @(negedge clk); upd = 1'b0;
        for (int e = 0; e < 50; e++) begin
            if (e == 10) begin
                n_tests++;
                if (led_d !== OFF_AL || led_l !== OFF_AL || led_a !== OFF_AH || busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_reset: got %h busy=%b done=%b want %h 0 0", led_d, busy, done, OFF_AL);
                end
                rst = 1'b0;
            end
            if (e > 10 && done) ndone++;
            if (e == 9) rst = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (ndone != 0 || led_d !== OFF_AL || led_a !== OFF_AH || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after: got done %0d led %h busy=%b want 0 %h 0", ndone, led_d, busy, OFF_AL);
        end
        exp_d = OFF_AL; exp_l = OFF_AL; exp_a = OFF_AH;
    endtask

    task automatic test_back_to_back();
        run_conv(12, 34, 56, "b2b_a");
        run_conv(56, 34, 12, "b2b_b");
    endtask

    initial begin
        exp_d = OFF_AL; exp_l = OFF_AL; exp_a = OFF_AH;
        test_reset();
        test_basic();
        test_edges();
        test_random();
        test_pending();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
